// File: rtl/mem_responder.sv
// Single-outstanding load/store responder in front of a synchronous single-port SRAM.
// Response pulse at accept+1 (error), +WAIT_STATES+2 (store), +WAIT_STATES+3 (load); req_ready low while busy.
module mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [31:0]   req_addr,
    input  logic [2:0]    req_funct3,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err,
    output logic          sram_en,
    output logic [3:0]    sram_we,
    output logic [AW-1:0] sram_addr,
    output logic [31:0]   sram_wdata,
    input  logic [31:0]   sram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_CAPTURE,
        S_RESP
    } state_e;

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    state_e        state_q, state_d;
    logic          we_q, we_d;
    logic [AW+1:0] addr_q, addr_d;
    logic [2:0]    f3_q, f3_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          err_q, err_d;
    logic [3:0]    cnt_q, cnt_d;
    logic [31:0]   rdata_q, rdata_d;

    logic          accept;
    logic          misaligned;
    logic          illegal_f3;
    logic          out_of_range;
    logic          req_err;
    logic [3:0]    lane_we;
    logic [31:0]   shifted;
    logic [31:0]   load_ext;

    assign accept = req_ready & req_valid;

    // Request checks are evaluated on the live port so the branch out of IDLE is decided at accept.
    always_comb begin
        misaligned   = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
        out_of_range = ((req_addr >> (AW + 2)) != 32'd0);
        illegal_f3   = 1'b1;
        if (req_we) begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010: illegal_f3 = 1'b0;
                default:                illegal_f3 = 1'b1;
            endcase
        end else begin
            case (req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: illegal_f3 = 1'b0;
                default:                                illegal_f3 = 1'b1;
            endcase
        end
        req_err = misaligned | illegal_f3 | out_of_range;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_err) begin
                        state_d = S_RESP;
                    end else if (WAIT_STATES > 0) begin
                        state_d = S_WAIT;
                    end else begin
                        state_d = S_ACCESS;
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS:  state_d = we_q ? S_RESP : S_CAPTURE;
            S_CAPTURE: state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    always_comb begin
        lane_we = 4'b0000;
        if (we_q) begin
            case (f3_q[1:0])
                2'b00:   lane_we = 4'b0001 << addr_q[1:0];
                2'b01:   lane_we = addr_q[1] ? 4'b1100 : 4'b0011;
                2'b10:   lane_we = 4'b1111;
                default: lane_we = 4'b0000;
            endcase
        end
    end

    // Reset gates every strobe combinationally so an in-flight store cannot land during reset.
    always_comb begin
        req_ready  = reset && (state_q == S_IDLE);
        rsp_valid  = reset && (state_q == S_RESP);
        rsp_err    = rsp_valid && err_q;
        sram_en    = reset && (state_q == S_ACCESS);
        sram_we    = sram_en ? lane_we : 4'b0000;
        sram_addr  = addr_q[AW+1:2];
        case (f3_q[1:0])
            2'b00:   sram_wdata = {4{wdata_q[7:0]}};
            2'b01:   sram_wdata = {2{wdata_q[15:0]}};
            default: sram_wdata = wdata_q;
        endcase
        rsp_rdata  = ((state_q == S_RESP) && (we_q || err_q)) ? 32'd0 : rdata_q;
    end

    always_comb begin
        shifted  = sram_rdata >> {addr_q[1:0], 3'b000};
        load_ext = shifted;
        case (f3_q)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_comb begin
        we_d    = we_q;
        addr_d  = addr_q;
        f3_d    = f3_q;
        wdata_d = wdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        if (accept) begin
            we_d    = req_we;
            addr_d  = req_addr[AW+1:0];
            f3_d    = req_funct3;
            wdata_d = req_wdata;
            err_d   = req_err;
            cnt_d   = WS;
        end
        if (state_q == S_WAIT) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (state_q == S_CAPTURE) begin
            rdata_d = load_ext;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            f3_q    <= 3'b000;
            wdata_q <= 32'd0;
            err_q   <= 1'b0;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
        end else begin
            we_q    <= we_d;
            addr_q  <= addr_d;
            f3_q    <= f3_d;
            wdata_q <= wdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
        end
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the multi-cycle RISC-V core. It accepts one load or store request at a time from the core's memory port, runs a configurable number of wait states, and drives a synchronous single-port SRAM with byte-lane write enables. It returns sign- or zero-extended load data, or flags an error, through a one-cycle response pulse. It sits between the core's address/data path and the data/instruction SRAM.

## Interface
Parameters:
- DEPTH_WORDS, default 1024: SRAM depth in 32-bit words; must be a power of two. AW = log2(DEPTH_WORDS).
- WAIT_STATES, default 1: extra idle cycles inserted before the SRAM access; valid range 0..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- req_valid  in  1  core request valid.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_funct3  in  3  access size and extension, RISC-V encoding: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- req_wdata  in  32  store data, right-aligned (unshifted).
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data.
- rsp_err  out  1  qualifies rsp_valid; the request was rejected.
- sram_en  out  1  SRAM access strobe.
- sram_we  out  4  byte write enables.
- sram_addr  out  AW  word address = req_addr[AW+1:2].
- sram_wdata  out  32  lane-replicated store data.
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en with sram_we = 0.

## Operation
- FSM states: IDLE, WAIT, ACCESS, CAPTURE, RESP.
- IDLE: req_ready = 1. On req_valid = 1, latch we/addr/funct3/wdata, run the checks below, then branch:
  - error → RESP with err set;
  - WAIT_STATES > 0 → WAIT;
  - otherwise → ACCESS.
- Error checks:
  - misaligned: h/hu with addr[0] = 1, or w with addr[1:0] ≠ 0;
  - illegal funct3: store with funct3 not in {000, 001, 010}, or load with funct3 not in {000, 001, 010, 100, 101};
  - out of range: addr[31:AW+2] ≠ 0.
  - An errored request never asserts sram_en.
- WAIT: a down-counter loaded with WAIT_STATES at accept; it decrements each WAIT cycle. Go to ACCESS when it reaches 1.
- ACCESS: sram_en = 1 for exactly one cycle.
  - Store byte lanes:
    - sb: sram_we = 1 << addr[1:0], sram_wdata = {4{wdata[7:0]}};
    - sh: sram_we = addr[1] ? 1100 : 0011, sram_wdata = {2{wdata[15:0]}};
    - sw: sram_we = 1111, sram_wdata = wdata.
  - Store → RESP. Load (sram_we = 0000) → CAPTURE.
- CAPTURE: shift sram_rdata right by 8·addr[1:0]. Extend to 32 bits: sign-extend for b/h, zero-extend for bu/hu. Register the result into rsp_rdata. → RESP.
- RESP: rsp_valid = 1 and req_ready = 0. rsp_err = 1 only for rejected requests. → IDLE.
- rsp_rdata:
  - is 0 in a store or error response;
  - holds its last load value otherwise, until the next CAPTURE or reset.
- rsp_err and rsp_valid are 0 outside RESP. sram_en and sram_we are 0 outside ACCESS.

## Timing
- An accept occurs at the clock edge where req_valid & req_ready = 1 (call it cycle 0). rsp_valid is high during:
  - error: cycle 1;
  - store: cycle WAIT_STATES + 2;
  - load: cycle WAIT_STATES + 3.
- One request is outstanding at most. req_ready is 0 from the cycle after accept through RESP.
- req_valid arriving while busy, including during RESP, is not accepted. The core holds it; it is accepted in the next IDLE cycle.
- Minimum accept-to-accept spacing is the response latency + 1 (for example, 3 cycles for a store with WAIT_STATES = 0).
- Responses have no backpressure; the core must sample on rsp_valid.
- Reset:
  - While reset = 0: state ← IDLE; counter, latched request and rsp_rdata ← 0.
  - During the reset cycle, req_ready, rsp_valid, rsp_err, sram_en and sram_we are forced to 0 combinationally. A store in ACCESS during reset therefore never writes.
  - req_ready returns to 1 in the first cycle with reset = 1.
- Reset values: req_ready 0 (1 once released), rsp_valid 0, rsp_rdata 0, rsp_err 0, sram_en 0, sram_we 0000, sram_addr 0, sram_wdata 0.

## Test plan
- WAIT_STATES = 0: sw addr 0x10, data 0xDEADBEEF → sram_en with sram_we = 1111 and sram_addr = 4 in cycle 1; rsp_valid in cycle 2. Then lw 0x10 → rsp_valid in cycle 3 with rsp_rdata = 0xDEADBEEF.
- sb 0x13, data 0x80 → sram_we = 1000, sram_wdata = 0x80808080. Then lb 0x13 → 0xFFFFFF80; lbu 0x13 → 0x00000080; lh 0x12 with SRAM word 0x80EF0000 → 0xFFFF80EF.
- Error responses: lw 0x11, sh 0x01, sw with funct3 = 100, and addr 0x1000 with DEPTH_WORDS = 1024 → each gives rsp_valid = 1, rsp_err = 1 in cycle 1 with no sram_en.
- WAIT_STATES = 3: lw → sram_en in cycle 4, rsp_valid in cycle 6. req_valid held high throughout → the second request is accepted in cycle 7, never earlier.
- Reset = 0 asserted in the ACCESS cycle of a store → sram_we = 0000 in that cycle, no rsp_valid, req_ready = 1 after release, and the SRAM contents are unchanged.
- Back-to-back stores to lanes 0–3 of word 0 (sb 0x11, 0x22, 0x33, 0x44), then lw 0 → 0x44332211.
